// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FSM state type and width helpers for the serial-MAC FIR
// Purpose: state encoding for the FIR control FSM plus constant functions that
//          derive the address, product and accumulator widths from the Q formats.
// Ports:   none (package).
package fir_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MAC  = 1'b1
  } state_t;

  function automatic int fir_clog2(input int v);
    int r;
    int t;
    r = 0;
    t = v - 1;
    while (t > 0) begin
      r++;
      t = t >> 1;
    end
    return r;
  endfunction

  // Full-precision product width: (WIX+WIC) integer bits, (WFX+WFC) fraction bits.
  function automatic int fir_prod_width(input int wix, input int wfx,
                                        input int wic, input int wfc);
    return wix + wfx + wic + wfc;
  endfunction

  // Accumulator adds clog2(N) guard bits so N worst-case products never wrap.
  function automatic int fir_acc_width(input int wix, input int wfx,
                                       input int wic, input int wfc,
                                       input int n);
    return fir_prod_width(wix, wfx, wic, wfc) + fir_clog2(n);
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// rtl/fir_mac_unit.sv - signed multiply-accumulate with clear and enable
// Purpose: one signed multiplier feeding a sign-extended accumulator register.
//          o_sum is the value the accumulator takes on the next enabled edge,
//          so the caller can capture the final sum in the same cycle as the
//          last accumulation.
// Ports:   i_clk, i_rst (async, active-high)
//          i_clear  - zero the accumulator (has priority over i_en)
//          i_en     - accumulate i_a*i_b
//          i_a, i_b - signed operands
//          o_sum    - accumulator + current product (combinational)
module fir_mac_unit #(
  parameter int WA   = 9,
  parameter int WB   = 9,
  parameter int WACC = 20
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clear,
  input  logic                   i_en,
  input  logic signed [WA-1:0]   i_a,
  input  logic signed [WB-1:0]   i_b,
  output logic signed [WACC-1:0] o_sum
);

  localparam int WP = WA + WB;

  logic signed [WP-1:0]   w_prod;
  logic signed [WACC-1:0] w_prod_ext;
  logic signed [WACC-1:0] r_acc;

  assign w_prod     = i_a * i_b;
  assign w_prod_ext = {{(WACC-WP){w_prod[WP-1]}}, w_prod};
  assign o_sum      = r_acc + w_prod_ext;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= o_sum;
    end
  end

endmodule

// File: rtl/fir_serial_mac.sv
// rtl/fir_serial_mac.sv - N-tap fixed-point FIR sharing one multiply-accumulator
// Purpose: accepts one sample in IDLE, then spends N cycles accumulating
//          x[k]*c[k] at full precision and reduces the sum to Q(WIO).(WFO).
//          Optional macro FIR_SATURATE_EN clamps Y on overflow instead of
//          wrapping; OF flags overflow in both builds.
// Ports:   CLK, RESET (async, active-high)
//          X, X_VALID, X_READY     - sample input handshake
//          C_WE, C_ADDR, C_DATA    - coefficient write port (IDLE only)
//          Y, Y_VALID, OF          - result, one-cycle strobe, overflow flag
module fir_serial_mac
  import fir_pkg::*;
#(
  parameter int WIX = 4,
  parameter int WFX = 5,
  parameter int WIC = 4,
  parameter int WFC = 5,
  parameter int WIO = 8,
  parameter int WFO = 10,
  parameter int N   = 4
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [WIX+WFX-1:0]           X,
  input  logic                         X_VALID,
  output logic                         X_READY,
  input  logic                         C_WE,
  input  logic [fir_clog2(N)-1:0]      C_ADDR,
  input  logic [WIC+WFC-1:0]           C_DATA,
  output logic [WIO+WFO-1:0]           Y,
  output logic                         Y_VALID,
  output logic                         OF
);

  localparam int CW  = fir_clog2(N);
  localparam int WX  = WIX + WFX;
  localparam int WC  = WIC + WFC;
  localparam int WA  = fir_acc_width(WIX, WFX, WIC, WFC, N);
  localparam int D   = (WFX + WFC) - WFO;   // fraction LSBs dropped
  localparam int WSH = WA - D;              // sum width after truncation
  localparam int WY  = WIO + WFO;
  localparam logic [WY-1:0] Y_MIN = WY'(1) << (WY - 1);
  localparam logic [WY-1:0] Y_MAX = ~Y_MIN;

  state_t r_state;
  state_t w_next_state;

  logic signed [WX-1:0] r_x [N];
  logic signed [WC-1:0] r_c [N];
  logic [CW-1:0]        r_cnt;

  logic                 w_accept;
  logic                 w_mac_en;
  logic                 w_last;
  logic                 w_c_we;
  logic signed [WA-1:0] w_sum;
  logic [WSH-1:0]       w_sh;
  logic [WSH-WY:0]      w_top;
  logic                 w_of;
  logic [WY-1:0]        w_y;

  // FSM state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state and control decode
  always_comb begin
    w_next_state = r_state;
    X_READY      = 1'b0;
    w_accept     = 1'b0;
    w_mac_en     = 1'b0;
    w_last       = 1'b0;
    w_c_we       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        X_READY = 1'b1;
        w_c_we  = C_WE;
        if (X_VALID) begin
          w_accept     = 1'b1;
          w_next_state = ST_MAC;
        end
      end
      ST_MAC: begin
        w_mac_en = 1'b1;
        if (r_cnt == CW'(N - 1)) begin
          w_last       = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  fir_mac_unit #(
    .WA   (WX),
    .WB   (WC),
    .WACC (WA)
  ) u_mac (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_clear (w_accept),
    .i_en    (w_mac_en),
    .i_a     (r_x[r_cnt]),
    .i_b     (r_c[r_cnt]),
    .o_sum   (w_sum)
  );

  // Truncation toward -inf is a plain arithmetic drop of the low bits.
  assign w_sh  = w_sum[WA-1:D];
  // Kept sign bit together with every discarded integer bit above it.
  assign w_top = w_sh[WSH-1:WY-1];
  assign w_of  = ~((&w_top) | ~(|w_top));

`ifdef FIR_SATURATE_EN
  assign w_y = w_of ? (w_sh[WSH-1] ? Y_MIN : Y_MAX) : w_sh[WY-1:0];
`else
  assign w_y = w_sh[WY-1:0];
`endif

  // Delay line, coefficient registers, tap counter and output register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int k = 0; k < N; k++) begin
        r_x[k] <= '0;
        r_c[k] <= '0;
      end
      r_cnt   <= '0;
      Y       <= '0;
      Y_VALID <= 1'b0;
      OF      <= 1'b0;
    end else begin
      if (w_c_we) begin
        r_c[C_ADDR] <= C_DATA;
      end
      if (w_accept) begin
        r_x[0] <= X;
        for (int k = 1; k < N; k++) begin
          r_x[k] <= r_x[k-1];
        end
        r_cnt <= '0;
      end else if (w_mac_en) begin
        r_cnt <= r_cnt + 1'b1;
      end
      Y_VALID <= w_last;
      if (w_last) begin
        Y  <= w_y;
        OF <= w_of;
      end
    end
  end

endmodule

// File: tb/tb_fir_serial_mac.sv
// tb/tb_fir_serial_mac.sv - directed self-checking bench for fir_serial_mac
module tb_fir_serial_mac;

  logic        CLK;
  logic        RESET;
  logic [8:0]  X;
  logic        X_VALID;
  logic        X_READY;
  logic        C_WE;
  logic [1:0]  C_ADDR;
  logic [8:0]  C_DATA;
  logic [17:0] Y;
  logic        Y_VALID;
  logic        OF;

  int n_cmp  = 0;
  int n_fail = 0;

  fir_serial_mac dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .X       (X),
    .X_VALID (X_VALID),
    .X_READY (X_READY),
    .C_WE    (C_WE),
    .C_ADDR  (C_ADDR),
    .C_DATA  (C_DATA),
    .Y       (Y),
    .Y_VALID (Y_VALID),
    .OF      (OF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic do_reset();
    RESET   = 1'b1;
    X       = '0;
    X_VALID = 1'b0;
    C_WE    = 1'b0;
    C_ADDR  = '0;
    C_DATA  = '0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic write_c(input logic [1:0] a, input logic [8:0] d);
    C_WE   = 1'b1;
    C_ADDR = a;
    C_DATA = d;
    @(negedge CLK);
    C_WE = 1'b0;
  endtask

  task automatic load_impulse_coeffs();
    write_c(2'd0, 9'd32);
    write_c(2'd1, 9'd16);
    write_c(2'd2, 9'd8);
    write_c(2'd3, 9'h1E0);
  endtask

  // Wait for a Y_VALID strobe at most 20 cycles; timed_out reports a miss.
  task automatic wait_result(output logic [17:0] y, output logic of, output bit timed_out);
    int n;
    n = 0;
    while (!Y_VALID && n < 20) begin
      @(negedge CLK);
      n++;
    end
    timed_out = !Y_VALID;
    y  = Y;
    of = OF;
  endtask

  task automatic push(input logic [8:0] x, output logic [17:0] y, output logic of, output bit timed_out);
    int n;
    n = 0;
    while (!X_READY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    X       = x;
    X_VALID = 1'b1;
    @(negedge CLK);
    X_VALID = 1'b0;
    wait_result(y, of, timed_out);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (X_READY !== 1'b1) begin n_fail++; $display("FAIL reset_x_ready got %b want 1", X_READY); end
    n_cmp++;
    if (Y_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_y_valid got %b want 0", Y_VALID); end
    n_cmp++;
    if (Y !== 18'h0) begin n_fail++; $display("FAIL reset_y got %h want 0", Y); end
    n_cmp++;
    if (OF !== 1'b0) begin n_fail++; $display("FAIL reset_of got %b want 0", OF); end
  endtask

  task automatic test_impulse();
    logic [17:0] y;
    logic        of;
    bit          to;
    logic [8:0]  xs  [4] = '{9'd32, 9'd0, 9'd0, 9'd0};
    logic [17:0] exp [4] = '{18'd1024, 18'd512, 18'd256, 18'h3FC00};
    do_reset();
    load_impulse_coeffs();
    for (int i = 0; i < 4; i++) begin
      push(xs[i], y, of, to);
      n_cmp++;
      if (to) begin n_fail++; $display("FAIL impulse_timeout[%0d] got no Y_VALID want Y_VALID", i); end
      n_cmp++;
      if (y !== exp[i]) begin n_fail++; $display("FAIL impulse_y[%0d] got %h want %h", i, y, exp[i]); end
      n_cmp++;
      if (of !== 1'b0) begin n_fail++; $display("FAIL impulse_of[%0d] got %b want 0", i, of); end
    end
  endtask

  task automatic test_overflow();
    logic [17:0] y;
    logic        of;
    bit          to;
`ifdef FIR_SATURATE_EN
    logic [17:0] exp [4] = '{18'h10000, 18'h1FFFF, 18'h1FFFF, 18'h1FFFF};
`else
    logic [17:0] exp [4] = '{18'h10000, 18'h20000, 18'h30000, 18'h00000};
`endif
    logic        eof [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int k = 0; k < 4; k++) write_c(k[1:0], 9'h100);
    for (int i = 0; i < 4; i++) begin
      push(9'h100, y, of, to);
      n_cmp++;
      if (to) begin n_fail++; $display("FAIL overflow_timeout[%0d] got no Y_VALID want Y_VALID", i); end
      n_cmp++;
      if (y !== exp[i]) begin n_fail++; $display("FAIL overflow_y[%0d] got %h want %h", i, y, exp[i]); end
      n_cmp++;
      if (of !== eof[i]) begin n_fail++; $display("FAIL overflow_of[%0d] got %b want %b", i, of, eof[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int acc_q[$];
    int yv_q[$];
    do_reset();
    X       = 9'd0;
    X_VALID = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      if (X_READY) acc_q.push_back(i);
      @(negedge CLK);
      if (Y_VALID) yv_q.push_back(i);
    end
    X_VALID = 1'b0;
    n_cmp++;
    if (acc_q.size() < 4) begin n_fail++; $display("FAIL b2b_accept_count got %0d want >=4", acc_q.size()); end
    n_cmp++;
    if (yv_q.size() < 4) begin n_fail++; $display("FAIL b2b_yvalid_count got %0d want >=4", yv_q.size()); end
    if (acc_q.size() >= 4 && yv_q.size() >= 4) begin
      n_cmp++;
      if (acc_q[0] !== 1) begin n_fail++; $display("FAIL b2b_first_accept got %0d want 1", acc_q[0]); end
      for (int k = 0; k < 4; k++) begin
        if (k > 0) begin
          n_cmp++;
          if (acc_q[k] - acc_q[k-1] !== 5)
            begin n_fail++; $display("FAIL b2b_interval[%0d] got %0d want 5", k, acc_q[k] - acc_q[k-1]); end
        end
        n_cmp++;
        if (yv_q[k] - acc_q[k] !== 4)
          begin n_fail++; $display("FAIL b2b_latency[%0d] got %0d want 4", k, yv_q[k] - acc_q[k]); end
      end
    end
  endtask

  task automatic test_coeff_write();
    logic [17:0] y;
    logic        of;
    bit          to;
    logic [17:0] exp1 [4] = '{18'd1024, 18'd512, 18'd256, 18'h3FC00};
    logic [17:0] exp2 [4] = '{18'd1024, 18'd512, 18'd512, 18'h3FC00};
    logic [8:0]  xs   [4] = '{9'd32, 9'd0, 9'd0, 9'd0};
    do_reset();
    load_impulse_coeffs();
    // Impulse accepted, then c[2]=0.5 attempted during MAC.
    X       = 9'd32;
    X_VALID = 1'b1;
    @(negedge CLK);
    X_VALID = 1'b0;
    write_c(2'd2, 9'd16);
    wait_result(y, of, to);
    n_cmp++;
    if (to || y !== exp1[0]) begin n_fail++; $display("FAIL cw_busy_y[0] got %h (timeout %0d) want %h", y, to, exp1[0]); end
    for (int i = 1; i < 4; i++) begin
      push(9'd0, y, of, to);
      n_cmp++;
      if (to || y !== exp1[i]) begin n_fail++; $display("FAIL cw_busy_y[%0d] got %h (timeout %0d) want %h", i, y, to, exp1[i]); end
    end
    write_c(2'd2, 9'd16);
    for (int i = 0; i < 4; i++) begin
      push(xs[i], y, of, to);
      n_cmp++;
      if (to || y !== exp2[i]) begin n_fail++; $display("FAIL cw_idle_y[%0d] got %h (timeout %0d) want %h", i, y, to, exp2[i]); end
    end
  endtask

  task automatic test_reset_mid_mac();
    logic [17:0] y;
    logic        of;
    bit          to;
    int          n_yv;
    logic [8:0]  xs [4] = '{9'd32, 9'd0, 9'd0, 9'd0};
    do_reset();
    load_impulse_coeffs();
    X       = 9'd32;
    X_VALID = 1'b1;
    @(negedge CLK);
    X_VALID = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    n_yv = 0;
    @(negedge CLK);
    if (Y_VALID) n_yv++;
    RESET = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (Y_VALID) n_yv++;
    end
    n_cmp++;
    if (n_yv !== 0) begin n_fail++; $display("FAIL rst_mid_yvalid got %0d pulses want 0", n_yv); end
    n_cmp++;
    if (Y !== 18'h0) begin n_fail++; $display("FAIL rst_mid_y got %h want 0", Y); end
    n_cmp++;
    if (OF !== 1'b0) begin n_fail++; $display("FAIL rst_mid_of got %b want 0", OF); end
    for (int i = 0; i < 4; i++) begin
      push(xs[i], y, of, to);
      n_cmp++;
      if (to || y !== 18'h0) begin n_fail++; $display("FAIL rst_mid_resp[%0d] got %h (timeout %0d) want 0", i, y, to); end
    end
  endtask

  initial begin
    RESET   = 1'b1;
    X       = '0;
    X_VALID = 1'b0;
    C_WE    = 1'b0;
    C_ADDR  = '0;
    C_DATA  = '0;
    test_reset();
    test_impulse();
    test_overflow();
    test_back_to_back();
    test_coeff_write();
    test_reset_mid_mac();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
